// File: rtl/wall_drawer_pkg.sv
// Shared game constants and types for the wall datapath and its drawer.
package wall_drawer_pkg;

  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned WALL_WIDTH  = 8;
  localparam int unsigned HOLE_HEIGHT = 40;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] WALL_COLOUR = 3'b010;
  localparam logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_e;

  // One pixel as presented to the VGA adapter
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/wall_drawer_pixel_scanner.sv
// Column-major x/y counter over a COLS x ROWS region; shared by erase and draw.
module wall_drawer_pixel_scanner
  import wall_drawer_pkg::*;
#(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 120
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           step_i,
  output logic [X_W-1:0] x_off_o,
  output logic [Y_W-1:0] y_o,
  output logic           start_o,
  output logic           last_o
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // Advance y first, then x; wrap to the origin after the last pixel
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (step_i) begin
      if (y_q == Y_W'(ROWS - 1)) begin
        y_d = '0;
        x_d = (x_q == X_W'(COLS - 1)) ? '0 : x_q + X_W'(1);
      end else begin
        y_d = y_q + Y_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_off_o = x_q;
  assign y_o     = y_q;
  assign start_o = (x_q == '0) && (y_q == '0);
  assign last_o  = (x_q == X_W'(COLS - 1)) && (y_q == Y_W'(ROWS - 1));

endmodule

// File: rtl/wall_drawer.sv
// Erases the previous wall column and draws the new one, one pixel per cycle.
module wall_drawer #(
  parameter int unsigned WALL_WIDTH  = wall_drawer_pkg::WALL_WIDTH,
  parameter int unsigned HOLE_HEIGHT = wall_drawer_pkg::HOLE_HEIGHT,
  parameter logic [2:0]  WALL_COLOUR = wall_drawer_pkg::WALL_COLOUR,
  parameter logic [2:0]  BG_COLOUR   = wall_drawer_pkg::BG_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] wall_x,
  input  logic [7:0] hole_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  import wall_drawer_pkg::*;

  state_e         state_q, state_d;
  logic [X_W-1:0] cur_x_q, cur_x_d;
  logic [7:0]     cur_hole_q, cur_hole_d;
  logic [X_W-1:0] prev_x_q, prev_x_d;
  logic           prev_valid_q, prev_valid_d;
  pixel_t         pix_q, pix_d;
  logic           plot_q, plot_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           scan_step;
  logic [X_W-1:0] scan_x;
  logic [Y_W-1:0] scan_y;
  logic           scan_at_start;
  logic           scan_last;

  logic           emit;
  logic           emit_erase;
  logic [X_W-1:0] base_x;
  logic [7:0]     hole_top;
  logic [8:0]     px_sum;
  logic [8:0]     hole_end;
  logic           in_hole;

  wall_drawer_pixel_scanner #(
    .COLS(WALL_WIDTH),
    .ROWS(SCREEN_H)
  ) u_scanner (
    .clk    (clk),
    .resetn (resetn),
    .step_i (scan_step),
    .x_off_o(scan_x),
    .y_o    (scan_y),
    .start_o(scan_at_start),
    .last_o (scan_last)
  );

  // Next state; each active edge registers the pixel at the scanner position
  always_comb begin
    state_d      = state_q;
    cur_x_d      = cur_x_q;
    cur_hole_d   = cur_hole_q;
    prev_x_d     = prev_x_q;
    prev_valid_d = prev_valid_q;
    pix_d        = pix_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    scan_step    = 1'b0;
    emit         = 1'b0;
    emit_erase   = 1'b0;
    base_x       = cur_x_q;
    hole_top     = cur_hole_q;

    case (state_q)
      S_IDLE: begin
        // A start in the same cycle as the done pulse is dropped
        if (start && !done_q && scan_at_start) begin
          cur_x_d    = wall_x;
          cur_hole_d = hole_y;
          emit       = 1'b1;
          emit_erase = prev_valid_q;
          base_x     = prev_valid_q ? prev_x_q : wall_x;
          hole_top   = hole_y;
          state_d    = prev_valid_q ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE: begin
        emit       = 1'b1;
        emit_erase = 1'b1;
        base_x     = prev_x_q;
        if (scan_last) begin
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        emit = 1'b1;
        if (scan_last) begin
          prev_x_d     = cur_x_q;
          prev_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // 9-bit arithmetic so neither the x sum nor the hole end can wrap
    px_sum   = 9'(base_x) + 9'(scan_x);
    hole_end = (9'(hole_top) >= 9'(SCREEN_H - HOLE_HEIGHT))
               ? 9'(SCREEN_H) : 9'(hole_top) + 9'(HOLE_HEIGHT);
    in_hole  = (9'(scan_y) >= 9'(hole_top)) && (9'(scan_y) < hole_end);

    if (emit) begin
      scan_step    = 1'b1;
      pix_d.x      = px_sum[X_W-1:0];
      pix_d.y      = scan_y;
      pix_d.colour = (emit_erase || in_hole) ? BG_COLOUR : WALL_COLOUR;
      plot_d       = (px_sum < 9'(SCREEN_W));
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cur_x_q      <= '0;
      cur_hole_q   <= '0;
      prev_x_q     <= '0;
      prev_valid_q <= 1'b0;
      pix_q        <= '{x: '0, y: '0, colour: BG_COLOUR};
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_x_q      <= cur_x_d;
      cur_hole_q   <= cur_hole_d;
      prev_x_q     <= prev_x_d;
      prev_valid_q <= prev_valid_d;
      pix_q        <= pix_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x  = pix_q.x;
  assign vga_y  = pix_q.y;
  assign colour = pix_q.colour;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_wall_drawer.sv
// Scoreboard bench for wall_drawer: expected pixels queued by the driver, popped by a monitor.
module tb_wall_drawer;
  import wall_drawer_pkg::*;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] wall_x;
  logic [7:0] hole_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_plot_cyc = -1;
  bit mon_chk = 1'b1;
  pixel_t exp_q[$];

  wall_drawer dut (
    .clk   (clk),
    .resetn(resetn),
    .start (start),
    .wall_x(wall_x),
    .hole_y(hole_y),
    .vga_x (vga_x),
    .vga_y (vga_y),
    .colour(colour),
    .plot  (plot),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every plotted pixel must match the head of the expected queue
  always @(negedge clk) begin
    if (resetn) begin
      if (plot) begin
        plot_cnt = plot_cnt + 1;
        if (first_plot_cyc < 0) first_plot_cyc = cyc;
        if (mon_chk) begin
          pixel_t e;
          checks = checks + 1;
          if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d", vga_x, vga_y, colour);
          end else begin
            e = exp_q.pop_front();
            if (vga_x !== e.x || vga_y !== e.y || colour !== e.colour) begin
              errors = errors + 1;
              $display("FAIL pixel got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d",
                       vga_x, vga_y, colour, e.x, e.y, e.colour);
            end
          end
        end
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // Queue expected pixels for one column region; returns how many are on screen
  function automatic int push_region(input int base, input bit erase, input int hy);
    int n = 0;
    for (int xo = 0; xo < 8; xo++) begin
      for (int y = 0; y < 120; y++) begin
        int xx;
        pixel_t p;
        xx = base + xo;
        if (xx < 160) begin
          p.x = 8'(xx);
          p.y = 7'(y);
          if (erase || (y >= hy && y < hy + 40)) p.colour = 3'b000;
          else p.colour = 3'b010;
          exp_q.push_back(p);
          n++;
        end
      end
    end
    return n;
  endfunction

  task automatic redraw(input int wx, input int hy, input bit has_erase, input int px,
                        input bit pulse_mid, input int exp_lat);
    int exp_n;
    int d0;
    int s;
    int n;
    bit first_on;
    exp_n = 0;
    if (has_erase) exp_n += push_region(px, 1'b1, 0);
    exp_n += push_region(wx, 1'b0, hy);
    first_on = has_erase ? (px < 160) : (wx < 160);
    plot_cnt = 0;
    first_plot_cyc = -1;
    d0 = done_cnt;
    @(negedge clk);
    wall_x = 8'(wx);
    hole_y = 8'(hy);
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b0;
    wall_x = 8'd7;
    hole_y = 8'd3;
    chk("busy_after_start", int'(busy), 1);
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      // Mid-redraw start pulse, and a start held during the done cycle
      start = (pulse_mid && n == 500) || (done === 1'b1);
    end
    start = 1'b0;
    if (n >= 4000) chk("done_timeout", 0, 1);
    chk("done_latency", done_cyc - s + 1, exp_lat);
    chk("plot_count", plot_cnt, exp_n);
    if (first_on) chk("first_plot_latency", first_plot_cyc - s + 1, 1);
    chk("queue_drained", exp_q.size(), 0);
    repeat (pulse_mid ? 2000 : 20) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("no_extra_done", done_cnt, d0 + 1);
    chk("no_extra_plots", plot_cnt, exp_n);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    wall_x = '0;
    hole_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_colour", int'(colour), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // First draw after reset: no erase
    redraw(100, 40, 1'b0, 0, 1'b0, 961);
    // Erase old column then draw new; ignored start mid-way
    redraw(96, 44, 1'b1, 100, 1'b1, 1921);
    // Right-edge clip and hole clamped at the bottom
    redraw(156, 100, 1'b1, 96, 1'b0, 1921);
    // x overflow past 255 must not wrap onto screen
    redraw(250, 0, 1'b1, 156, 1'b0, 1921);

    // Reset in the middle of DRAW
    mon_chk = 1'b0;
    @(negedge clk);
    wall_x = 8'd40;
    hole_y = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (1200) @(posedge clk);
    #1;
    chk("mid_draw_plot", int'(plot), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_plot_drop", int'(plot), 0);
    chk("reset_busy_drop", int'(busy), 0);
    chk("reset_vga_x", int'(vga_x), 0);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    mon_chk = 1'b1;
    repeat (2) @(posedge clk);

    // After reset the next redraw must skip the erase
    redraw(20, 0, 1'b0, 0, 1'b0, 961);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
